mem_stage: RTL and testbench

Load/store stage of the pipelined RV32I core, between the ALU stage and the writeback unit. Takes the ALU-computed effective address, store data and destination register, performs one access on the single-port data RAM via a req/gnt/rvalid handshake, then lane-selects and sign- or zero-extends load data. Non-memory ops pass the ALU result through. One result is presented to writeback per accepted op.

---
 rtl/mem_stage_pkg.sv | 83 ++++++++
 rtl/mem_stage_load_align.sv | 25 ++
 rtl/mem_stage.sv | 185 ++++++++++++++++++
 tb/tb_mem_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types, byte-enable constants and decode helpers for the load/store stage.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    LB       = 4'd1,
    LH       = 4'd2,
    LW       = 4'd3,
    LBU      = 4'd4,
    LHU      = 4'd5,
    SB       = 4'd6,
    SH       = 4'd7,
    SW       = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } mem_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Map the raw op field onto the enum; unknown encodings behave as MEM_NONE.
  function automatic mem_op_t decode_op(input logic [3:0] raw);
    case (raw)
      4'd1:    decode_op = LB;
      4'd2:    decode_op = LH;
      4'd3:    decode_op = LW;
      4'd4:    decode_op = LBU;
      4'd5:    decode_op = LHU;
      4'd6:    decode_op = SB;
      4'd7:    decode_op = SH;
      4'd8:    decode_op = SW;
      default: decode_op = MEM_NONE;
    endcase
  endfunction

  function automatic logic is_load(input mem_op_t op);
    case (op)
      LB, LH, LW, LBU, LHU: is_load = 1'b1;
      default:              is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input mem_op_t op);
    case (op)
      SB, SH, SW: is_store = 1'b1;
      default:    is_store = 1'b0;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] off);
    case (op)
      LH, LHU, SH: is_misaligned = off[0];
      LW, SW:      is_misaligned = (off != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

  // Loads always read the whole word; stores enable only the lanes they write.
  function automatic logic [3:0] byte_enable(input mem_op_t op, input logic [1:0] off);
    case (op)
      SB:      byte_enable = BE_BYTE << off;
      SH:      byte_enable = BE_HALF << off;
      default: byte_enable = BE_WORD;
    endcase
  endfunction

  // Replicate the store data across every lane so the RAM picks it up via byte enables.
  function automatic logic [31:0] store_wdata(input mem_op_t op, input logic [31:0] d);
    case (op)
      SB:      store_wdata = {4{d[7:0]}};
      SH:      store_wdata = {2{d[15:0]}};
      SW:      store_wdata = d;
      default: store_wdata = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load lane select and sign/zero extension of the returned RAM word.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  mem_op_t     op,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Bring the addressed byte/halfword down to bit 0, then extend it.
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (op)
      LB:      data = {{24{shifted[7]}}, shifted[7:0]};
      LBU:     data = {24'd0, shifted[7:0]};
      LH:      data = {{16{shifted[15]}}, shifted[15:0]};
      LHU:     data = {16'd0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Load/store pipeline stage: one RAM access per op via req/gnt/rvalid, one
// registered result pulse to writeback per accepted op.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd_addr,
  input  logic        in_rd_we,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        misaligned
);

  mem_state_t  state_r, state_nxt;
  mem_op_t     op_r, op_nxt;
  logic [1:0]  off_r, off_nxt;
  logic        rd_we_r, rd_we_nxt;
  logic        mem_req_r, mem_req_nxt;
  logic        mem_we_r, mem_we_nxt;
  logic [3:0]  mem_be_r, mem_be_nxt;
  logic [31:0] mem_addr_r, mem_addr_nxt;
  logic [31:0] mem_wdata_r, mem_wdata_nxt;
  logic        wb_valid_r, wb_valid_nxt;
  logic        wb_we_r, wb_we_nxt;
  logic [4:0]  wb_rd_addr_r, wb_rd_addr_nxt;
  logic [31:0] wb_data_r, wb_data_nxt;
  logic        misaligned_r, misaligned_nxt;

  mem_op_t     in_op_dec;
  logic [31:0] load_data;

  assign in_op_dec = decode_op(in_op);

  load_align u_load_align (
    .rdata (mem_rdata),
    .off   (off_r),
    .op    (op_r),
    .data  (load_data)
  );

  // Next-state and next-output logic; wb_valid/wb_we/misaligned default low so results pulse.
  always_comb begin
    state_nxt      = state_r;
    op_nxt         = op_r;
    off_nxt        = off_r;
    rd_we_nxt      = rd_we_r;
    mem_req_nxt    = mem_req_r;
    mem_we_nxt     = mem_we_r;
    mem_be_nxt     = mem_be_r;
    mem_addr_nxt   = mem_addr_r;
    mem_wdata_nxt  = mem_wdata_r;
    wb_valid_nxt   = 1'b0;
    wb_we_nxt      = 1'b0;
    misaligned_nxt = 1'b0;
    wb_rd_addr_nxt = wb_rd_addr_r;
    wb_data_nxt    = wb_data_r;

    case (state_r)
      IDLE: begin
        if (in_valid) begin
          op_nxt         = in_op_dec;
          off_nxt        = in_addr[1:0];
          wb_rd_addr_nxt = in_rd_addr;
          rd_we_nxt      = in_rd_we && (in_rd_addr != 5'd0) && !is_store(in_op_dec);
          if (!is_load(in_op_dec) && !is_store(in_op_dec)) begin
            // Non-memory op: pass the ALU result straight through.
            wb_valid_nxt = 1'b1;
            wb_we_nxt    = in_rd_we && (in_rd_addr != 5'd0);
            wb_data_nxt  = in_addr;
          end else if (is_misaligned(in_op_dec, in_addr[1:0])) begin
            // Fault: report the offending address, never touch the RAM.
            wb_valid_nxt   = 1'b1;
            misaligned_nxt = 1'b1;
            wb_data_nxt    = in_addr;
          end else begin
            state_nxt     = REQ;
            mem_req_nxt   = 1'b1;
            mem_we_nxt    = is_store(in_op_dec);
            mem_be_nxt    = byte_enable(in_op_dec, in_addr[1:0]);
            mem_addr_nxt  = {in_addr[31:2], 2'b00};
            mem_wdata_nxt = store_wdata(in_op_dec, in_store_data);
          end
        end else begin
          state_nxt = IDLE;
        end
      end

      REQ: begin
        if (mem_gnt) begin
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          if (is_store(op_r)) begin
            wb_valid_nxt = 1'b1;
            state_nxt    = IDLE;
          end else begin
            state_nxt = WAIT_R;
          end
        end else begin
          state_nxt = REQ;
        end
      end

      WAIT_R: begin
        if (mem_rvalid) begin
          wb_valid_nxt = 1'b1;
          wb_we_nxt    = rd_we_r;
          wb_data_nxt  = load_data;
          state_nxt    = IDLE;
        end else begin
          state_nxt = WAIT_R;
        end
      end

      default: begin
        state_nxt   = IDLE;
        mem_req_nxt = 1'b0;
        mem_we_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      op_r         <= MEM_NONE;
      off_r        <= 2'd0;
      rd_we_r      <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_be_r     <= 4'd0;
      mem_addr_r   <= 32'd0;
      mem_wdata_r  <= 32'd0;
      wb_valid_r   <= 1'b0;
      wb_we_r      <= 1'b0;
      wb_rd_addr_r <= 5'd0;
      wb_data_r    <= 32'd0;
      misaligned_r <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      op_r         <= op_nxt;
      off_r        <= off_nxt;
      rd_we_r      <= rd_we_nxt;
      mem_req_r    <= mem_req_nxt;
      mem_we_r     <= mem_we_nxt;
      mem_be_r     <= mem_be_nxt;
      mem_addr_r   <= mem_addr_nxt;
      mem_wdata_r  <= mem_wdata_nxt;
      wb_valid_r   <= wb_valid_nxt;
      wb_we_r      <= wb_we_nxt;
      wb_rd_addr_r <= wb_rd_addr_nxt;
      wb_data_r    <= wb_data_nxt;
      misaligned_r <= misaligned_nxt;
    end
  end

  assign in_ready   = (state_r == IDLE);
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_be     = mem_be_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign wb_valid   = wb_valid_r;
  assign wb_we      = wb_we_r;
  assign wb_rd_addr = wb_rd_addr_r;
  assign wb_data    = wb_data_r;
  assign misaligned = misaligned_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage with a small handshake-driving RAM model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd_addr;
  logic        in_rd_we;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        misaligned;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_addr(in_addr), .in_store_data(in_store_data),
    .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        rd_we;
    int          g;        // gnt in cycle T+g
    int          r;        // rvalid in cycle T+r
    logic [31:0] rdata;
    logic        exp_req;
    logic        exp_mem_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    logic        exp_wb_we;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(
    input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
    input logic [4:0] rd, input logic rd_we, input int g, input int r,
    input logic [31:0] rdata, input logic exp_req, input logic exp_mem_we,
    input logic [3:0] exp_be, input logic [31:0] exp_wdata,
    input logic [31:0] exp_data, input logic exp_wb_we, input logic exp_mis);
    vec_t v;
    v.op = op; v.addr = addr; v.sdata = sdata; v.rd = rd; v.rd_we = rd_we;
    v.g = g; v.r = r; v.rdata = rdata; v.exp_req = exp_req;
    v.exp_mem_we = exp_mem_we; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
    v.exp_data = exp_data; v.exp_wb_we = exp_wb_we; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one table vector, acting as the RAM, and check every visible step.
  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({t, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_op = v.op; in_addr = v.addr; in_store_data = v.sdata;
    in_rd_addr = v.rd; in_rd_we = v.rd_we;
    tick();
    in_valid = 1'b0;
    if (!v.exp_req) begin
      chk({t, ".wb_valid"}, wb_valid, 1);
      chk({t, ".mem_req"}, mem_req, 0);
      chk({t, ".wb_data"}, wb_data, v.exp_data);
      chk({t, ".wb_we"}, wb_we, v.exp_wb_we);
      chk({t, ".misaligned"}, misaligned, v.exp_mis);
      if (!v.exp_mis) chk({t, ".wb_rd_addr"}, wb_rd_addr, v.rd);
    end else begin
      chk({t, ".mem_req"}, mem_req, 1);
      chk({t, ".wb_valid_req"}, wb_valid, 0);
      chk({t, ".mem_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
      chk({t, ".mem_be"}, mem_be, v.exp_be);
      chk({t, ".mem_we"}, mem_we, v.exp_mem_we);
      if (v.exp_mem_we) chk({t, ".mem_wdata"}, mem_wdata, v.exp_wdata);
      for (int i = 1; i < v.g; i++) begin
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;  // must be ignored in REQ
        tick();
        chk({t, ".req_hold"}, mem_req, 1);
        chk({t, ".addr_hold"}, mem_addr, v.addr & 32'hFFFF_FFFC);
        chk({t, ".be_hold"}, mem_be, v.exp_be);
        chk({t, ".wb_valid_stall"}, wb_valid, 0);
        if (v.exp_mem_we) chk({t, ".wdata_hold"}, mem_wdata, v.exp_wdata);
      end
      mem_rvalid = 1'b0;
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk({t, ".req_drop"}, mem_req, 0);
      if (v.exp_mem_we) begin
        chk({t, ".st_wb_valid"}, wb_valid, 1);
        chk({t, ".st_wb_we"}, wb_we, 0);
        chk({t, ".st_mis"}, misaligned, 0);
      end else begin
        chk({t, ".ld_wait_valid"}, wb_valid, 0);
        chk({t, ".ld_in_ready"}, in_ready, 0);
        for (int i = v.g + 1; i < v.r; i++) begin
          tick();
          chk({t, ".ld_wait_valid"}, wb_valid, 0);
        end
        mem_rvalid = 1'b1; mem_rdata = v.rdata;
        tick();
        mem_rvalid = 1'b0;
        chk({t, ".ld_wb_valid"}, wb_valid, 1);
        chk({t, ".ld_wb_data"}, wb_data, v.exp_data);
        chk({t, ".ld_wb_we"}, wb_we, v.exp_wb_we);
        chk({t, ".ld_wb_rd"}, wb_rd_addr, v.rd);
        chk({t, ".ld_mis"}, misaligned, 0);
      end
    end
    tick();
    chk({t, ".pulse_end"}, wb_valid, 0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_addr = 32'd0;
    in_store_data = 32'd0; in_rd_addr = 5'd0; in_rd_we = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;

    //           op        addr          sdata         rd     we  g  r  rdata         req mwe be       wdata         data          wbwe mis
    vecs[0]  = mk(MEM_NONE, 32'h0000_1234, 32'h0,        5'd5,  1, 0, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0000_1234, 1, 0);
    vecs[1]  = mk(MEM_NONE, 32'hDEAD_BEEF, 32'h0,        5'd0,  1, 0, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        32'hDEAD_BEEF, 0, 0);
    vecs[2]  = mk(SB,       32'h0000_0103, 32'hAABBCCDD, 5'd3,  1, 3, 0, 32'h0,        1, 1, 4'b1000, 32'hDDDDDDDD, 32'h0,         0, 0);
    vecs[3]  = mk(SH,       32'h0000_0102, 32'h12345678, 5'd3,  1, 1, 0, 32'h0,        1, 1, 4'b1100, 32'h56785678, 32'h0,         0, 0);
    vecs[4]  = mk(SW,       32'h0000_0204, 32'hCAFEF00D, 5'd3,  1, 2, 0, 32'h0,        1, 1, 4'b1111, 32'hCAFEF00D, 32'h0,         0, 0);
    vecs[5]  = mk(LB,       32'h0000_0102, 32'h0,        5'd7,  1, 1, 2, 32'h0080_0000, 1, 0, 4'b1111, 32'h0,       32'hFFFF_FF80, 1, 0);
    vecs[6]  = mk(LBU,      32'h0000_0102, 32'h0,        5'd7,  1, 1, 2, 32'h0080_0000, 1, 0, 4'b1111, 32'h0,       32'h0000_0080, 1, 0);
    vecs[7]  = mk(LH,       32'h0000_0102, 32'h0,        5'd9,  1, 2, 4, 32'h8001_0000, 1, 0, 4'b1111, 32'h0,       32'hFFFF_8001, 1, 0);
    vecs[8]  = mk(LHU,      32'h0000_0102, 32'h0,        5'd9,  1, 2, 4, 32'h8001_0000, 1, 0, 4'b1111, 32'h0,       32'h0000_8001, 1, 0);
    vecs[9]  = mk(LW,       32'h0000_0106, 32'h0,        5'd4,  1, 0, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0000_0106, 0, 1);
    vecs[10] = mk(SH,       32'h0000_0101, 32'h1111,     5'd4,  1, 0, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0000_0101, 0, 1);
    vecs[11] = mk(LW,       32'h0000_0200, 32'h0,        5'd0,  1, 2, 6, 32'h1234_5678, 1, 0, 4'b1111, 32'h0,       32'h1234_5678, 0, 0);
    vecs[12] = mk(4'hF,     32'h0000_0055, 32'h0,        5'd3,  1, 0, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0000_0055, 1, 0);
    vecs[13] = mk(LB,       32'h0000_0101, 32'h0,        5'd8,  1, 1, 3, 32'h0000_7F00, 1, 0, 4'b1111, 32'h0,       32'h0000_007F, 1, 0);
    vecs[14] = mk(LH,       32'h0000_0100, 32'h0,        5'd8,  1, 1, 2, 32'h0000_FFFE, 1, 0, 4'b1111, 32'h0,       32'hFFFF_FFFE, 1, 0);
    vecs[15] = mk(LW,       32'h0000_0104, 32'h0,        5'd31, 1, 1, 2, 32'hA5A5_A5A5, 1, 0, 4'b1111, 32'h0,       32'hA5A5_A5A5, 1, 0);
    vecs[16] = mk(LHU,      32'h0000_0103, 32'h0,        5'd2,  1, 0, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0000_0103, 0, 1);

    // Reset values.
    #12;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.mem_req", mem_req, 0);
    chk("rst.mem_we", mem_we, 0);
    chk("rst.mem_be", mem_be, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.wb_valid", wb_valid, 0);
    chk("rst.wb_we", wb_we, 0);
    chk("rst.wb_data", wb_data, 0);
    chk("rst.wb_rd_addr", wb_rd_addr, 0);
    chk("rst.misaligned", misaligned, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Stale rvalid right after reset must not produce a result.
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    tick();
    chk("stale.wb_valid", wb_valid, 0);
    mem_rvalid = 1'b0;

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Back-to-back MEM_NONE at full rate.
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_op = MEM_NONE; in_addr = 32'h1000 + k;
      in_rd_addr = 5'(k + 1); in_rd_we = 1'b1;
      tick();
      chk("b2b.wb_valid", wb_valid, 1);
      chk("b2b.wb_data", wb_data, 32'h1000 + k);
      chk("b2b.wb_rd_addr", wb_rd_addr, 32'(k + 1));
      chk("b2b.in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("b2b.end", wb_valid, 0);

    // in_valid held high during a load: next op only taken on the wb_valid cycle.
    @(negedge clk);
    in_valid = 1'b1; in_op = LW; in_addr = 32'h300; in_rd_addr = 5'd9; in_rd_we = 1'b1;
    tick();
    in_op = MEM_NONE; in_addr = 32'h77; in_rd_addr = 5'd4;
    chk("hold.in_ready_req", in_ready, 0);
    chk("hold.mem_req", mem_req, 1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("hold.in_ready_wait", in_ready, 0);
    chk("hold.wb_valid_wait", wb_valid, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
    tick();
    mem_rvalid = 1'b0;
    chk("hold.ld_valid", wb_valid, 1);
    chk("hold.ld_data", wb_data, 32'h1122_3344);
    chk("hold.ld_rd", wb_rd_addr, 32'd9);
    chk("hold.in_ready_wb", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("hold.next_valid", wb_valid, 1);
    chk("hold.next_data", wb_data, 32'h77);
    chk("hold.next_rd", wb_rd_addr, 32'd4);
    tick();
    chk("hold.end", wb_valid, 0);

    // Reset while a store request is pending: mem_req drops at once.
    @(negedge clk);
    in_valid = 1'b1; in_op = SW; in_addr = 32'h500; in_store_data = 32'h0BAD_F00D; in_rd_addr = 5'd1;
    tick();
    in_valid = 1'b0;
    chk("rstreq.mem_req_before", mem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstreq.mem_req", mem_req, 0);
    chk("rstreq.mem_addr", mem_addr, 0);
    chk("rstreq.in_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rstreq.no_wb", wb_valid, 0);
    chk("rstreq.no_req", mem_req, 0);

    // Reset in WAIT_R, then a stale rvalid.
    @(negedge clk);
    in_valid = 1'b1; in_op = LB; in_addr = 32'h600; in_rd_addr = 5'd6;
    tick();
    in_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rstwait.in_ready_before", in_ready, 0);
    reset_n = 1'b0;
    #1;
    chk("rstwait.wb_valid", wb_valid, 0);
    chk("rstwait.mem_req", mem_req, 0);
    chk("rstwait.in_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_00FF;
    tick();
    chk("rstwait.stale1", wb_valid, 0);
    tick();
    chk("rstwait.stale2", wb_valid, 0);
    mem_rvalid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
